mem_port_arbiter: RTL

//  Shares the single core memory port between instruction fetch (IF) and load/store (LSU).

---
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 106 ++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the IF fetcher, the LSU, the arbiter and the memory bridge.
// The arbiter takes the master view; the environment (requesters + memory) takes the slave view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic                  if_req_valid;
  logic [ADDR_W-1:0]     if_req_addr;
  logic                  if_req_ready;
  logic                  if_rsp_valid;
  logic [DATA_W-1:0]     if_rsp_data;

  logic                  lsu_req_valid;
  logic                  lsu_req_we;
  logic [ADDR_W-1:0]     lsu_req_addr;
  logic [DATA_W-1:0]     lsu_req_wdata;
  logic [DATA_W/8-1:0]   lsu_req_wmask;
  logic                  lsu_req_ready;
  logic                  lsu_rsp_valid;
  logic [DATA_W-1:0]     lsu_rsp_data;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_we;
  logic [ADDR_W-1:0]     mem_req_addr;
  logic [DATA_W-1:0]     mem_req_wdata;
  logic [DATA_W/8-1:0]   mem_req_wmask;
  logic                  mem_rsp_valid;
  logic [DATA_W-1:0]     mem_rsp_data;

  modport master (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    input  lsu_req_valid, lsu_req_we, lsu_req_addr, lsu_req_wdata, lsu_req_wmask,
    output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport slave (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    output lsu_req_valid, lsu_req_we, lsu_req_addr, lsu_req_wdata, lsu_req_wmask,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and LSU, one transaction in flight.
// LSU has priority; a saturating starvation counter forces an IF grant after STARVE_LIM LSU wins.
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_LIM = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus,
  output logic               busy
);
  localparam int                CW  = $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0]     LIM = CW'(STARVE_LIM);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t                r_state;
  logic                  r_owner_lsu;
  logic [CW-1:0]         r_starve;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W/8-1:0]   r_wmask;
  logic                  r_if_rsp_valid;
  logic [DATA_W-1:0]     r_if_rsp_data;
  logic                  r_lsu_rsp_valid;
  logic [DATA_W-1:0]     r_lsu_rsp_data;

  logic w_idle, w_if_win, w_lsu_win;

  // Grants are gated by rst so readies stay low while reset is held.
  assign w_idle    = (r_state == S_IDLE) && rst;
  assign w_if_win  = w_idle && bus.if_req_valid && (!bus.lsu_req_valid || r_starve == LIM);
  assign w_lsu_win = w_idle && bus.lsu_req_valid && !w_if_win;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state         <= S_IDLE;
      r_owner_lsu     <= 1'b0;
      r_starve        <= '0;
      r_we            <= 1'b0;
      r_addr          <= '0;
      r_wdata         <= '0;
      r_wmask         <= '0;
      r_if_rsp_valid  <= 1'b0;
      r_if_rsp_data   <= '0;
      r_lsu_rsp_valid <= 1'b0;
      r_lsu_rsp_data  <= '0;
    end else begin
      r_if_rsp_valid  <= 1'b0;
      r_lsu_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_if_win) begin
            r_owner_lsu <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= bus.if_req_addr;
            r_wdata     <= '0;
            r_wmask     <= '0;
            r_starve    <= '0;
            r_state     <= S_REQ;
          end else if (w_lsu_win) begin
            r_owner_lsu <= 1'b1;
            r_we        <= bus.lsu_req_we;
            r_addr      <= bus.lsu_req_addr;
            r_wdata     <= bus.lsu_req_wdata;
            r_wmask     <= bus.lsu_req_wmask;
            if (!bus.if_req_valid)  r_starve <= '0;
            else if (r_starve != LIM) r_starve <= r_starve + 1'b1;
            r_state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.mem_req_ready) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.mem_rsp_valid) begin
            if (r_owner_lsu) begin
              r_lsu_rsp_valid <= 1'b1;
              r_lsu_rsp_data  <= bus.mem_rsp_data;
            end else begin
              r_if_rsp_valid  <= 1'b1;
              r_if_rsp_data   <= bus.mem_rsp_data;
            end
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.if_req_ready  = w_if_win;
  assign bus.lsu_req_ready = w_lsu_win;
  assign bus.if_rsp_valid  = r_if_rsp_valid;
  assign bus.if_rsp_data   = r_if_rsp_data;
  assign bus.lsu_rsp_valid = r_lsu_rsp_valid;
  assign bus.lsu_rsp_data  = r_lsu_rsp_data;
  assign bus.mem_req_valid = (r_state == S_REQ);
  assign bus.mem_req_we    = r_we;
  assign bus.mem_req_addr  = r_addr;
  assign bus.mem_req_wdata = r_wdata;
  assign bus.mem_req_wmask = r_wmask;
  assign busy              = (r_state != S_IDLE);
endmodule
